// File: rtl/spi_arb_pkg.sv
// -----------------------------------------------------------------------------
// spi_arb_pkg
// Shared types and helpers for the SPI bus arbiter.
//   state_e    : arbiter state (IDLE = no owner, OWN = one channel holds the bus)
//   ptr_width(): width of an index able to address n items (ceil log2, min 1)
// -----------------------------------------------------------------------------
package spi_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: selects the first set bit of req at or
// after index ptr, wrapping modulo N_CH.
// Ports:
//   req  : per-channel request vector
//   ptr  : starting index of the search (always < N_CH in use)
//   pick : one-hot selection, all-zero when req is all-zero
// -----------------------------------------------------------------------------
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int PTR_W = ptr_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_CH-1:0]  pick
);

  always_comb begin
    logic found;
    int   idx;
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(ptr) + k) % N_CH;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// -----------------------------------------------------------------------------
// spi_arbiter
// Round-robin arbiter granting one of N_CH channels ownership of an SPI bus
// until that channel signals done. The granted channel's bundle is muxed onto
// spi_in.
// Optional feature: define SPI_ARB_TIMEOUT_EN to force release of an owner
// that holds the bus for TIMEOUT cycles without done; a one-cycle timeout
// pulse follows. Without the macro, timeout is tied low and TIMEOUT is unused.
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   req     : per-channel request level
//   done    : per-channel end-of-transaction pulse (only the owner's counts)
//   ch_out  : packed channel bundles, channel i at [i*SIZE +: SIZE]
//   grant   : registered one-hot grant, zero when idle
//   spi_in  : bundle of the granted channel, zero when no grant
//   busy    : high while a grant is held
//   timeout : one-cycle pulse after a forced release
// -----------------------------------------------------------------------------
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_CH    = 3,
  parameter int SIZE    = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      req,
  input  logic [N_CH-1:0]      done,
  input  logic [N_CH*SIZE-1:0] ch_out,
  output logic [N_CH-1:0]      grant,
  output logic [SIZE-1:0]      spi_in,
  output logic                 busy,
  output logic                 timeout
);

  localparam int PTR_W = ptr_width(N_CH);

  state_e            state_q, state_d;
  logic [N_CH-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]  ptr_q,   ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic              timeout_q, timeout_d;

  logic [N_CH-1:0]   pick;
  logic [PTR_W-1:0]  pick_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic              owner_done;

  rr_pick #(
    .N_CH  (N_CH),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick)
  );

  // Binary index of the one-hot pick, stored so the pointer can advance past
  // the owner on release.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  // With a single channel this always yields 0.
  assign next_ptr   = (owner_q == PTR_W'(N_CH - 1)) ? '0 : owner_q + 1'b1;
  assign owner_done = done[owner_q];

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = ptr_width(TIMEOUT);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_expired;
  assign hold_expired = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        // done is ignored here; any request starts a new ownership.
        if (|req) begin
          state_d = OWN;
          grant_d = pick;
          owner_d = pick_idx;
`ifdef SPI_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      OWN: begin
        // The owner's req level is irrelevant while it holds the bus; done
        // wins over an expiring hold on the same edge.
        if (owner_done) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = next_ptr;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (hold_expired) begin
          state_d   = IDLE;
          grant_d   = '0;
          ptr_d     = next_ptr;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // AND-OR mux keyed on the registered grant; non-granted slices give zero.
  always_comb begin
    spi_in = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_q[i]) spi_in = spi_in | ch_out[i*SIZE +: SIZE];
    end
  end

  assign grant = grant_q;
  assign busy  = |grant_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_arbiter
// Scoreboard bench for spi_arbiter (N_CH=3, SIZE=8, TIMEOUT=16). The driver
// applies inputs on the falling edge, advances a reference model of the bus
// ownership rules and queues the outputs expected after the next rising edge;
// a monitor compares them 1 time unit after each rising edge.
// Define SPI_ARB_TIMEOUT_EN for both DUT and bench to cover forced release.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_arbiter;

  localparam int N  = 3;
  localparam int SZ = 8;
  localparam int TO = 16;

  typedef struct {
    logic [N-1:0]  grant;
    logic [SZ-1:0] spi_in;
    logic          busy;
    logic          timeout;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    done = '0;
  logic [N*SZ-1:0] ch_out = '0;
  logic [N-1:0]    grant;
  logic [SZ-1:0]   spi_in;
  logic            busy;
  logic            timeout;

  int total = 0;
  int bad   = 0;
  exp_t sb_q[$];

  // Reference model: who owns the bus, where the rotation starts next, how
  // long the current owner has held it, and whether a forced release just
  // happened.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  spi_arbiter #(
    .N_CH    (N),
    .SIZE    (SZ),
    .TIMEOUT (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .ch_out  (ch_out),
    .grant   (grant),
    .spi_in  (spi_in),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_to    = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model over the coming edge and
  // queue what the outputs must look like afterwards.
  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] d, input logic [N*SZ-1:0] c);
    exp_t e;
    logic [N*SZ-1:0] cv;
    @(negedge clk);
    req    = r;
    done   = d;
    ch_out = c;
    m_to   = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
      m_held = 0;
    end else begin
      m_held++;
      if (d[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
`ifdef SPI_ARB_TIMEOUT_EN
      else if (m_held == TO) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_to    = 1'b1;
      end
`endif
    end
    cv        = c;
    e.grant   = (m_owner < 0) ? '0 : N'(1 << m_owner);
    e.spi_in  = (m_owner < 0) ? '0 : cv[m_owner*SZ +: SZ];
    e.busy    = (m_owner >= 0);
    e.timeout = m_to;
    sb_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n, input logic [N-1:0] r);
    for (int i = 0; i < n; i++) drive(r, '0, N*SZ'({$urandom, $urandom}));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("grant",   64'(grant),   64'(e.grant));
        check("spi_in",  64'(spi_in),  64'(e.spi_in));
        check("busy",    64'(busy),    64'(e.busy));
        check("timeout", 64'(timeout), 64'(e.timeout));
      end
    end
  end

  initial begin : stim
    logic [N-1:0] rr, dd;
    int waited;
    // Reset state
    #2;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_spi",   64'(spi_in), 64'd0);
    check("rst_to",    64'(timeout), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Arbitration from ptr 0 with channels 1,2 requesting -> channel 1
    drive(3'b110, 3'b000, 24'hA5_3C_11);
    idle_cycles(2, 3'b111);
    // Owner done while everyone requests: one idle cycle, then channel 2
    drive(3'b111, 3'b010, 24'h01_02_03);
    drive(3'b111, 3'b000, 24'hC3_77_55);
    idle_cycles(1, 3'b111);
    // Owner 2 done, then wrap-around to channel 0
    drive(3'b011, 3'b100, 24'h10_20_30);
    drive(3'b011, 3'b000, 24'h44_55_66);
    // Non-owner done and owner's req dropped: ownership held
    drive(3'b010, 3'b010, 24'h9A_BC_DE);
    // Long hold with no done: forced release when the timeout is built in
    idle_cycles(TO + 4, 3'b000);
    // Make sure someone owns the bus, then reset between edges
    drive(3'b111, 3'b000, 24'h12_34_56);
    idle_cycles(2, 3'b111);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_grant", 64'(grant),   64'd0);
    check("async_busy",  64'(busy),    64'd0);
    check("async_spi",   64'(spi_in),  64'd0);
    check("async_to",    64'(timeout), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(3'b001, 3'b000, 24'hFE_DC_BA);
    drive(3'b000, 3'b001, 24'h0F_0F_0F);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rr = N'($urandom_range(0, 7));
      dd = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 7)) : '0;
      drive(rr, dd, N*SZ'({$urandom, $urandom}));
    end

    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
